// File: rtl/hc_sub_pipe16.sv
// Three-stage Han-Carlson prefix subtractor: a - b - bin, with borrow and overflow.
// Global-stall handshake; odd-bit prefix tree split 2+2 levels, even fill in S3.
module hc_sub_pipe16 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        bin,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] diff,
  output logic        bout,
  output logic        ovf
);

  logic stall;
  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;

  // S1: propagate/generate of a + ~b, cin = ~bin
  logic [15:0] s1_p, s1_g;
  logic        s1_cin, s1_a15, s1_b15, s1_v;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v   <= 1'b0;
      s1_p   <= '0;
      s1_g   <= '0;
      s1_cin <= 1'b0;
      s1_a15 <= 1'b0;
      s1_b15 <= 1'b0;
    end else if (!stall) begin
      s1_v   <= in_valid & in_ready;
      s1_p   <= a ^ ~b;
      s1_g   <= a & ~b;
      s1_cin <= ~bin;
      s1_a15 <= a[15];
      s1_b15 <= b[15];
    end
  end

  // Odd bit k = 2j+1 is held at index j; group P is dropped once a group reaches bit -1
  logic [7:0] l1g, l2g, ge1;
  logic [7:1] l1p;
  logic [7:2] l2p;

  always_comb begin
    l1g[0] = s1_g[1] | (s1_p[1] & (s1_g[0] | (s1_p[0] & s1_cin)));
    l1p    = '0;
    for (int j = 1; j < 8; j++) begin
      l1g[j] = s1_g[2*j+1] | (s1_p[2*j+1] & s1_g[2*j]);
      l1p[j] = s1_p[2*j+1] & s1_p[2*j];
    end
    l2g[0] = l1g[0];
    l2g[1] = l1g[1] | (l1p[1] & l1g[0]);
    l2p    = '0;
    for (int j = 2; j < 8; j++) begin
      l2g[j] = l1g[j] | (l1p[j] & l1g[j-1]);
      l2p[j] = l1p[j] & l1p[j-1];
    end
    for (int j = 0; j < 8; j++)
      ge1[j] = s1_g[2*j];
  end

  // S2
  logic [7:0]  s2_og, s2_ge;
  logic [7:2]  s2_op;
  logic [15:0] s2_p;
  logic        s2_cin, s2_a15, s2_b15, s2_v;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_v   <= 1'b0;
      s2_og  <= '0;
      s2_op  <= '0;
      s2_ge  <= '0;
      s2_p   <= '0;
      s2_cin <= 1'b0;
      s2_a15 <= 1'b0;
      s2_b15 <= 1'b0;
    end else if (!stall) begin
      s2_v   <= s1_v;
      s2_og  <= l2g;
      s2_op  <= l2p;
      s2_ge  <= ge1;
      s2_p   <= s1_p;
      s2_cin <= s1_cin;
      s2_a15 <= s1_a15;
      s2_b15 <= s1_b15;
    end
  end

  // Levels 3-4 (spans 4 and 8 bits), even fill, post-computation
  logic [7:0]  l3g, l4g;
  logic [7:4]  l3p;
  logic [16:0] c;
  logic [15:0] dn;
  logic        ov;

  always_comb begin
    l3g[1:0] = s2_og[1:0];
    for (int j = 2; j < 8; j++)
      l3g[j] = s2_og[j] | (s2_op[j] & s2_og[j-2]);
    l3p = '0;
    for (int j = 4; j < 8; j++)
      l3p[j] = s2_op[j] & s2_op[j-2];
    l4g[3:0] = l3g[3:0];
    for (int j = 4; j < 8; j++)
      l4g[j] = l3g[j] | (l3p[j] & l3g[j-4]);
    c[0] = s2_cin;
    c[1] = s2_ge[0] | (s2_p[0] & s2_cin);
    for (int j = 0; j < 8; j++)
      c[2*j+2] = l4g[j];
    for (int j = 1; j < 8; j++)
      c[2*j+1] = s2_ge[j] | (s2_p[2*j] & l4g[j-1]);
    dn = s2_p ^ c[15:0];
    ov = (s2_a15 ^ s2_b15) & (s2_a15 ^ dn[15]);
  end

  // S3 / output
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      diff      <= '0;
      bout      <= 1'b0;
      ovf       <= 1'b0;
    end else if (!stall) begin
      out_valid <= s2_v;
      diff      <= dn;
      bout      <= ~c[16];
      ovf       <= ov;
    end
  end

endmodule

// File: tb/tb_hc_sub_pipe16.sv
// Directed and random checks for hc_sub_pipe16.
// Expected results come from hand values or an arithmetic model.
module tb_hc_sub_pipe16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a, b;
  logic        bin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] diff;
  logic        bout;
  logic        ovf;

  int checks = 0;
  int errors = 0;
  logic [17:0] expq[$];

  hc_sub_pipe16 dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .bin(bin),
    .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .bout(bout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [17:0] model(input logic [15:0] x,
                                        input logic [15:0] y,
                                        input logic bi);
    logic [16:0] u;
    int s;
    logic o;
    u = {1'b0, x} - {1'b0, y} - {16'd0, bi};
    s = int'($signed(x)) - int'($signed(y)) - int'(bi);
    o = (s > 32767) || (s < -32768);
    return {u[15:0], u[16], o};
  endfunction

  // One cycle: drive, check the presented result, then cross one edge.
  task automatic cyc(input logic v, input logic [15:0] aa,
                     input logic [15:0] bb, input logic bi,
                     input logic ordy, input logic hand,
                     input logic [17:0] hexp);
    logic [17:0] e;
    in_valid  = v;
    a         = aa;
    b         = bb;
    bin       = bi;
    out_ready = ordy;
    #1;
    chk("in_ready", {31'd0, in_ready}, {31'd0, !(out_valid && !ordy)});
    if (out_valid) begin
      if (expq.size() == 0) begin
        chk("unexpected_result", 32'd1, 32'd0);
      end else begin
        e = expq[0];
        chk("diff", {16'd0, diff}, {16'd0, e[17:2]});
        chk("bout", {31'd0, bout}, {31'd0, e[1]});
        chk("ovf", {31'd0, ovf}, {31'd0, e[0]});
        if (ordy) void'(expq.pop_front());
      end
    end
    if (v && in_ready) expq.push_back(hand ? hexp : model(aa, bb, bi));
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic ordy);
    cyc(1'b0, 16'h0, 16'h0, 1'b0, ordy, 1'b0, 18'h0);
  endtask

  task automatic hop(input logic [15:0] aa, input logic [15:0] bb,
                     input logic bi, input logic [15:0] ed,
                     input logic eb, input logic eo);
    cyc(1'b1, aa, bb, bi, 1'b1, 1'b1, {ed, eb, eo});
  endtask

  task automatic rop(input logic ordy);
    cyc(1'b1, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)),
        ordy, 1'b0, 18'h0);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    bin       = 1'b0;
    out_ready = 1'b1;
    #12;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_diff", {16'd0, diff}, 32'd0);
    chk("rst_bout", {31'd0, bout}, 32'd0);
    chk("rst_ovf", {31'd0, ovf}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Latency: result appears three edges after acceptance
    hop(16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, 1'b0);
    chk("lat1", {31'd0, out_valid}, 32'd0);
    idle(1'b1);
    chk("lat2", {31'd0, out_valid}, 32'd0);
    idle(1'b1);
    chk("lat3", {31'd0, out_valid}, 32'd1);

    // Hand-computed vectors, back to back
    hop(16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0);
    hop(16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0);
    hop(16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1);
    hop(16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1);
    hop(16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0);
    hop(16'h1234, 16'h1234, 1'b0, 16'h0000, 1'b0, 1'b0);
    hop(16'h8000, 16'h7FFF, 1'b0, 16'h0001, 1'b0, 1'b1);
    hop(16'hAAAA, 16'h5555, 1'b1, 16'h5554, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) idle(1'b1);
    chk("drain_directed", expq.size(), 32'd0);

    // Random back-to-back stream
    for (int i = 0; i < 1000; i++) rop(1'b1);
    for (int i = 0; i < 4; i++) idle(1'b1);
    chk("drain_stream", expq.size(), 32'd0);

    // Stall for 5 cycles with operands still offered
    for (int i = 0; i < 20; i++) rop(!(i >= 5 && i < 10));
    for (int i = 0; i < 12; i++) begin
      if ($urandom_range(0, 2) == 0) rop(1'b0);
      else rop(1'($urandom_range(0, 1)));
    end
    for (int i = 0; i < 20 && expq.size() != 0; i++) idle(1'b1);
    chk("drain_stall", expq.size(), 32'd0);

    // Reset with three operations in flight
    rop(1'b1);
    rop(1'b1);
    rop(1'b1);
    chk("full_before_rst", {31'd0, out_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_diff", {16'd0, diff}, 32'd0);
    chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    expq.delete();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) idle(1'b1);
    hop(16'h0100, 16'h0001, 1'b1, 16'h00FE, 1'b0, 1'b0);
    chk("post_rst_lat1", {31'd0, out_valid}, 32'd0);
    idle(1'b1);
    chk("post_rst_lat2", {31'd0, out_valid}, 32'd0);
    idle(1'b1);
    chk("post_rst_lat3", {31'd0, out_valid}, 32'd1);
    idle(1'b1);
    idle(1'b1);
    chk("drain_final", expq.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
